// File: rtl/md_seq_if.sv
// Bundle between the execute stage, the md_seq sequencer and the combinational muldiv unit.
// The master side is the pipeline and muldiv; the slave side is the sequencer.
interface md_seq_if #(
    parameter int DWIDTH = 32
);
    logic              Start;
    logic [2:0]        Func;
    logic [DWIDTH-1:0] RS1;
    logic [DWIDTH-1:0] RS2;
    logic              Flush;
    logic [DWIDTH-1:0] MdA;
    logic [DWIDTH-1:0] MdB;
    logic [2:0]        MdFunc;
    logic [DWIDTH-1:0] MdOut;
    logic [DWIDTH-1:0] Result;
    logic              ResultValid;
    logic              Busy;
    logic              Stall;

    modport master (
        output Start, Func, RS1, RS2, Flush, MdOut,
        input  MdA, MdB, MdFunc, Result, ResultValid, Busy, Stall
    );

    modport slave (
        input  Start, Func, RS1, RS2, Flush, MdOut,
        output MdA, MdB, MdFunc, Result, ResultValid, Busy, Stall
    );
endinterface

// File: rtl/md_seq.sv
// Multi-cycle sequencer for the M-extension: holds operands on muldiv for LAT cycles,
// stalls the pipeline, resolves divide-by-zero / signed-overflow itself, strobes the result.
module md_seq #(
    parameter int DWIDTH = 32,
    parameter int LAT    = 3
) (
    input logic     Clock,
    input logic     nReset,
    md_seq_if.slave bus
);
    localparam int             CW       = $clog2(LAT + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LAT - 1);
    localparam logic [DWIDTH-1:0] INT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              launch;
    logic              div_zero;
    logic              overflow;
    logic              load_special;
    logic              capture;
    logic [DWIDTH-1:0] special_res;

    // Corner cases are judged on the live operands, since they are latched on the same edge.
    always_comb begin
        div_zero = bus.Func[2] && (bus.RS2 == '0);
        overflow = ((bus.Func == 3'b100) || (bus.Func == 3'b110))
                   && (bus.RS1 == INT_MIN) && (&bus.RS2);
        if (div_zero)
            special_res = bus.Func[1] ? bus.RS1 : '1;
        else
            special_res = bus.Func[1] ? '0 : bus.RS1;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        load_special = 1'b0;
        capture      = 1'b0;
        launch       = (state == S_IDLE) && bus.Start && !bus.Flush;

        unique case (state)
            S_IDLE: begin
                if (launch) begin
                    if (div_zero || overflow) begin
                        load_special = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything: abandon the operation and leave Result untouched.
        if (bus.Flush) begin
            state_d      = S_IDLE;
            load_special = 1'b0;
            capture      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bus.MdA    <= '0;
            bus.MdB    <= '0;
            bus.MdFunc <= 3'b000;
            bus.Result <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (launch) begin
                bus.MdA    <= bus.RS1;
                bus.MdB    <= bus.RS2;
                bus.MdFunc <= bus.Func;
            end
            if (load_special)
                bus.Result <= special_res;
            else if (capture)
                bus.Result <= bus.MdOut;
        end
    end

    // Stall drops in DONE so the pipeline advances while the result is presented.
    always_comb begin
        bus.Busy        = (state != S_IDLE);
        bus.ResultValid = (state == S_DONE);
        bus.Stall       = launch || (state == S_WAIT);
    end
endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq: a LAT=3 instance for the main scenarios and a LAT=1
// instance for the short-window case after an asynchronous reset.
module tb_md_seq;
    localparam int          LAT3 = 3;
    localparam logic [31:0] GARB = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    md_seq_if #(.DWIDTH(32)) bus3 ();
    md_seq_if #(.DWIDTH(32)) bus1 ();

    md_seq #(.DWIDTH(32), .LAT(LAT3)) u_dut3 (
        .Clock  (clk),
        .nReset (rst_n),
        .bus    (bus3)
    );

    md_seq #(.DWIDTH(32), .LAT(1)) u_dut1 (
        .Clock  (clk),
        .nReset (rst_n),
        .bus    (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Normal path on the LAT=3 instance; MdOut carries md only during cycle LAT.
    task automatic launch_normal(input string tag, input logic [2:0] func,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] md, input logic [31:0] exp);
        bus3.Start = 1'b1;
        bus3.Func  = func;
        bus3.RS1   = a;
        bus3.RS2   = b;
        bus3.MdOut = GARB;
        #1;
        check({tag, ".stall_c0"}, 32'(bus3.Stall), 32'd1);
        for (int c = 1; c <= LAT3; c++) begin
            tick();
            if (c == LAT3) bus3.MdOut = md;
            #1;
            check($sformatf("%s.stall_c%0d", tag, c), 32'(bus3.Stall), 32'd1);
            check($sformatf("%s.valid_c%0d", tag, c), 32'(bus3.ResultValid), 32'd0);
            if (c == 1) check({tag, ".mda"}, bus3.MdA, a);
        end
        tick();
        bus3.MdOut = GARB;
        bus3.Start = 1'b0;
        #1;
        check({tag, ".valid"}, 32'(bus3.ResultValid), 32'd1);
        check({tag, ".result"}, bus3.Result, exp);
        check({tag, ".stall_done"}, 32'(bus3.Stall), 32'd0);
        tick();
        check({tag, ".valid_after"}, 32'(bus3.ResultValid), 32'd0);
        check({tag, ".busy_after"}, 32'(bus3.Busy), 32'd0);
    endtask

    task automatic launch_special(input string tag, input logic [2:0] func,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] exp);
        bus3.Start = 1'b1;
        bus3.Func  = func;
        bus3.RS1   = a;
        bus3.RS2   = b;
        bus3.MdOut = GARB;
        #1;
        check({tag, ".stall_c0"}, 32'(bus3.Stall), 32'd1);
        tick();
        bus3.Start = 1'b0;
        #1;
        check({tag, ".valid_c1"}, 32'(bus3.ResultValid), 32'd1);
        check({tag, ".result"}, bus3.Result, exp);
        check({tag, ".stall_c1"}, 32'(bus3.Stall), 32'd0);
        tick();
        check({tag, ".valid_c2"}, 32'(bus3.ResultValid), 32'd0);
        check({tag, ".busy_c2"}, 32'(bus3.Busy), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus3.Start = 1'b0; bus3.Func = 3'b000; bus3.RS1 = '0; bus3.RS2 = '0;
        bus3.Flush = 1'b0; bus3.MdOut = GARB;
        bus1.Start = 1'b0; bus1.Func = 3'b000; bus1.RS1 = '0; bus1.RS2 = '0;
        bus1.Flush = 1'b0; bus1.MdOut = GARB;
        #3;
        check("rst.mda", bus3.MdA, 32'h0);
        check("rst.mdb", bus3.MdB, 32'h0);
        check("rst.mdfunc", 32'(bus3.MdFunc), 32'h0);
        check("rst.result", bus3.Result, 32'h0);
        check("rst.valid", 32'(bus3.ResultValid), 32'd0);
        check("rst.busy", 32'(bus3.Busy), 32'd0);
        check("rst.stall", 32'(bus3.Stall), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // MUL 6*7: result strobed in cycle LAT+1
        launch_normal("mul", 3'b000, 32'd6, 32'd7, 32'd42, 32'd42);

        // Divide-by-zero and signed-overflow shortcuts
        launch_special("divu0", 3'b101, 32'h1234, 32'h0, 32'hFFFF_FFFF);
        launch_special("remu0", 3'b111, 32'h1234, 32'h0, 32'h1234);
        launch_special("div0",  3'b100, 32'h5678, 32'h0, 32'hFFFF_FFFF);
        launch_special("rem0",  3'b110, 32'h5678, 32'h0, 32'h5678);
        launch_special("divov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        launch_normal("divuov", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
        launch_special("remov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Result now holds 0 from the signed REM overflow; give it a distinct value first.
        launch_normal("mul2", 3'b000, 32'd11, 32'd3, 32'd33, 32'd33);

        // Flush in cycle 2 of a MUL: no strobe, Result kept, relaunch in cycle 3
        bus3.Start = 1'b1; bus3.Func = 3'b000; bus3.RS1 = 32'd3; bus3.RS2 = 32'd5;
        bus3.MdOut = GARB;
        tick();
        check("flush.valid_c1", 32'(bus3.ResultValid), 32'd0);
        check("flush.busy_c1", 32'(bus3.Busy), 32'd1);
        tick();
        bus3.Flush = 1'b1;
        #1;
        check("flush.valid_c2", 32'(bus3.ResultValid), 32'd0);
        tick();
        bus3.Flush = 1'b0;
        #1;
        check("flush.busy_c3", 32'(bus3.Busy), 32'd0);
        check("flush.valid_c3", 32'(bus3.ResultValid), 32'd0);
        check("flush.result_kept", bus3.Result, 32'd33);
        launch_normal("relaunch", 3'b000, 32'd9, 32'd9, 32'd81, 32'd81);

        // Flush with Start in IDLE does not launch
        bus3.Start = 1'b1; bus3.Flush = 1'b1;
        #1;
        check("flushidle.stall", 32'(bus3.Stall), 32'd0);
        tick();
        check("flushidle.busy", 32'(bus3.Busy), 32'd0);
        bus3.Start = 1'b0; bus3.Flush = 1'b0;

        // Start held, operands toggling during WAIT and DONE
        bus3.Start = 1'b1; bus3.Func = 3'b000; bus3.RS1 = 32'd2; bus3.RS2 = 32'd3;
        bus3.MdOut = GARB;
        tick();
        bus3.RS1 = 32'd100; bus3.RS2 = 32'd200;
        #1;
        check("held.mda_c1", bus3.MdA, 32'd2);
        check("held.mdb_c1", bus3.MdB, 32'd3);
        tick();
        bus3.RS1 = 32'd55;
        tick();
        bus3.MdOut = 32'd6;
        #1;
        check("held.mda_c3", bus3.MdA, 32'd2);
        check("held.mdb_c3", bus3.MdB, 32'd3);
        tick();
        bus3.MdOut = GARB;
        #1;
        check("held.valid_c4", 32'(bus3.ResultValid), 32'd1);
        check("held.result", bus3.Result, 32'd6);
        tick();
        check("held.busy_c5", 32'(bus3.Busy), 32'd0);
        check("held.stall_c5", 32'(bus3.Stall), 32'd1);
        check("held.mda_c5", bus3.MdA, 32'd2);
        tick();
        check("held.busy_c6", 32'(bus3.Busy), 32'd1);
        check("held.mda_c6", bus3.MdA, 32'd55);
        check("held.mdb_c6", bus3.MdB, 32'd200);
        bus3.Flush = 1'b1;
        tick();
        bus3.Flush = 1'b0; bus3.Start = 1'b0;
        #1;
        check("held.busy_flushed", 32'(bus3.Busy), 32'd0);

        // Asynchronous reset mid-WAIT
        bus3.Start = 1'b1; bus3.Func = 3'b000; bus3.RS1 = 32'd8; bus3.RS2 = 32'd8;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        bus3.Start = 1'b0;
        #1;
        check("arst.busy", 32'(bus3.Busy), 32'd0);
        check("arst.mda", bus3.MdA, 32'h0);
        check("arst.mdb", bus3.MdB, 32'h0);
        check("arst.mdfunc", 32'(bus3.MdFunc), 32'h0);
        check("arst.result", bus3.Result, 32'h0);
        check("arst.valid", 32'(bus3.ResultValid), 32'd0);
        check("arst.stall", 32'(bus3.Stall), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();

        // LAT=1 instance: valid in cycle 2 of a fresh launch
        bus1.Start = 1'b1; bus1.Func = 3'b000; bus1.RS1 = 32'd4; bus1.RS2 = 32'd5;
        bus1.MdOut = GARB;
        #1;
        check("lat1.stall_c0", 32'(bus1.Stall), 32'd1);
        tick();
        bus1.MdOut = 32'd20;
        #1;
        check("lat1.busy_c1", 32'(bus1.Busy), 32'd1);
        check("lat1.valid_c1", 32'(bus1.ResultValid), 32'd0);
        check("lat1.stall_c1", 32'(bus1.Stall), 32'd1);
        tick();
        bus1.Start = 1'b0;
        bus1.MdOut = GARB;
        #1;
        check("lat1.valid_c2", 32'(bus1.ResultValid), 32'd1);
        check("lat1.result", bus1.Result, 32'd20);
        tick();
        check("lat1.busy_c3", 32'(bus1.Busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/md_seq.md
# md_seq

Multi-cycle sequencer for the M-extension datapath. It sits between the execute stage and the combinational `muldiv` unit. It latches the instruction's operands and function code and holds them stable on the `muldiv` inputs for a fixed settling window, stalling the pipeline meanwhile. It then captures `MDOut`, resolves the RISC-V divide corner cases itself, and returns the result with a one-cycle valid strobe.

## Interface
- `DWIDTH`, default 32: operand and result width.
- `LAT`, default 3: number of cycles `muldiv` is given to settle (multicycle path). `LAT >= 1`.

Ports:
- `Clock`, in, 1: single clock, rising edge.
- `nReset`, in, 1: reset, asynchronous, active-low.
- `Start`, in, 1: execute stage holds an M-extension instruction; held high by the pipeline while stalled.
- `Func`, in, 3: M-extension function code, same encoding as `MDFunc` (000 MUL … 111 REMU).
- `RS1`, in, `DWIDTH`: operand A (dividend).
- `RS2`, in, `DWIDTH`: operand B (divisor).
- `Flush`, in, 1: pipeline flush; abandons any operation in progress.
- `MdA`, out, `DWIDTH`: registered operand A to `muldiv.A`.
- `MdB`, out, `DWIDTH`: registered operand B to `muldiv.B`.
- `MdFunc`, out, 3: registered function code to `muldiv.MDFunc`.
- `MdOut`, in, `DWIDTH`: `muldiv.MDOut`.
- `Result`, out, `DWIDTH`: registered result.
- `ResultValid`, out, 1: one-cycle strobe; `Result` is valid.
- `Busy`, out, 1: state is not IDLE.
- `Stall`, out, 1: freeze the pipeline front end.

## Operation
- **States:** IDLE, WAIT, DONE. Counter width is `$clog2(LAT+1)`.
- **IDLE, `Start=1`, `Flush=0`:** latch `RS1`/`RS2`/`Func` into `MdA`/`MdB`/`MdFunc`, then evaluate the special cases.
  - Divide by zero: `Func[2]=1` and `RS2=0`.
  - Signed overflow: `Func` is 100 or 110, `RS1=1<<(DWIDTH-1)`, and `RS2` is all ones.
  - If either special case holds: load `Result` from the rule below and go to DONE.
  - Otherwise: counter ← `LAT-1`, go to WAIT.
- **Special results:**
  - DIV or DIVU by zero → all ones.
  - REM or REMU by zero → `RS1`.
  - DIV overflow → `RS1` (0x80000000 at 32 bits).
  - REM overflow → 0.
- **WAIT:** while counter ≠ 0, decrement. When counter = 0: `Result` ← `MdOut`, go to DONE.
- **DONE:** `ResultValid=1` for exactly this cycle, then go to IDLE unconditionally. `Start` is not sampled in DONE.
- **`Start` outside IDLE:** ignored. Operands and function are not re-sampled.
- **`Flush`:** has priority over everything. In any state, next state is IDLE, `ResultValid` stays 0 on that edge, and `Result` keeps its old value. `Flush` together with `Start` in IDLE does not launch.
- **Outputs:**
  - `Busy` = (state ≠ IDLE).
  - `Stall` = (IDLE ∧ `Start` ∧ ¬`Flush`) ∨ WAIT. This is combinational from `Start`. It is 0 in DONE, so the pipeline advances in the same cycle the result is presented.
- **Data handling:** `Result` and `MdOut` are passed bit-exact; no sign or width manipulation beyond the special cases. `MdA`/`MdB`/`MdFunc` hold their values after completion until the next launch.

## Timing
- **Reset** (async assert, sync-safe deassert): state IDLE, counter 0, `MdA`=`MdB`=0, `MdFunc`=000, `Result`=0, `ResultValid`=0, `Busy`=0. `Stall` follows its equation, so it is 0 while state is IDLE and `Start` is low.
- **Normal launch:** `Start` seen in IDLE at edge 0; WAIT occupies cycles 1..`LAT`. `MdOut` is sampled at the edge ending cycle `LAT`. DONE and `ResultValid` are in cycle `LAT+1`.
  - Total latency is `LAT+1` cycles from launch to valid.
  - `Stall` is high for cycles 0..`LAT`.
- **Special-case launch:** DONE in cycle 1 (latency 1). `Stall` is high only in cycle 0.
- **Throughput:** the earliest next launch is the cycle after DONE, i.e. one idle cycle minimum between operations.
- **Reset mid-operation:** immediate return to reset values; no `ResultValid`.
- **`LAT=1`:** WAIT lasts one cycle, and `MdOut` is captured at the end of it.

## Test plan
- **MUL, `LAT`=3:** `Func`=000, `RS1`=6, `RS2`=7, bench model drives `MdOut`=42 only during cycle 3 → `Stall` high in cycles 0–3; `ResultValid`=1 with `Result`=42 in cycle 4 only; `Busy` low in cycle 5.
- **DIVU by zero:** `Func`=101, `RS1`=0x1234, `RS2`=0 → `ResultValid` in cycle 1 with `Result`=0xFFFFFFFF; `MdOut` ignored. Repeat with `Func`=111 → `Result`=0x1234.
- **DIV overflow:** `Func`=100, `RS1`=0x80000000, `RS2`=0xFFFFFFFF → `Result`=0x80000000 in cycle 1. With `Func`=110 → `Result`=0. With `Func`=101 (unsigned) → normal `LAT+1` path.
- **Flush mid-WAIT:** launch MUL, assert `Flush` in cycle 2 → IDLE in cycle 3; no `ResultValid` pulse at any point; `Result` unchanged. A new launch in cycle 3 completes normally.
- **`Start` held and changing operands:** keep `Start` high while toggling `RS1`/`RS2` during WAIT → `MdA`/`MdB` constant, `Result` equals `MdOut` for the original operands. The next launch happens only from IDLE, after DONE.
- **Async reset:** drop `nReset` mid-cycle in WAIT → all outputs at reset values immediately. After release, a `LAT`=1 build gives `ResultValid` in cycle 2 of a fresh launch.
